uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
- Serial program loader: the writer side of instruction memory, which the fetch stage reads.
- Receives 8N1 UART bytes from the host and assembles them big-endian into 32-bit MIPS words.
- Issues one-cycle write strobes into instruction memory at auto-incrementing byte addresses.
- Holds the CPU pipeline in reset while a load session is active.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be >= 4)
ADDR_W, 10, width of byte address to instruction memory

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
rx  in  1  UART serial input, idle high, asynchronous to clock
load_en  in  1  load session enable (switch); level-sensitive
wr_en  out  1  one-cycle write strobe to instruction memory
wr_addr  out  ADDR_W  byte address of word being written (multiple of 4)
wr_data  out  32  word being written
cpu_hold  out  1  high while session active; OR'd into pipeline reset
word_count  out  16  words written in current/last session
frame_err  out  1  sticky: a byte had a low stop bit
checksum  out  8  running byte sum (see Optional Feature)

Behaviour:
- Reset (async):
  - All outputs 0.
  - rx 2-flop synchroniser flops reset to 1.
  - Both FSMs go to IDLE; byte index 0; address 0.
- RX FSM (sampled on synchronised rx, baud counter counts 0..CLKS_PER_BIT-1):
  - IDLE: falling edge on synced rx -> START; counter cleared.
  - START: at CLKS_PER_BIT/2, re-sample. Low -> DATA. High -> IDLE (glitch; no byte, no error).
  - DATA: sample every CLKS_PER_BIT (mid-bit); 8 bits, LSB first -> STOP.
  - STOP: sample at mid-bit. High -> byte_valid pulse for 1 cycle. Low -> set frame_err, no byte_valid. Either way -> IDLE.
  - Byte latency: byte_valid fires ~9.5 bit times after the start edge, plus 2 sync cycles.
- Loader FSM:
  - IDLE: load_en high -> LOAD. On entry: cpu_hold=1, address=0, byte index=0, word_count=0, frame_err=0, checksum=0.
  - LOAD, on byte_valid:
    - Byte goes to shift slot index (0 -> wr_data[31:24], …, 3 -> [7:0]); index increments.
    - On the 4th byte, the next cycle has wr_en=1 with the complete word and the current address.
    - After the write: address += 4 (wraps modulo 2^ADDR_W), word_count += 1 (wraps at 2^16), index=0.
  - LOAD, on load_en low -> IDLE. Partial word is discarded; cpu_hold drops the following cycle.
  - Bytes completing while in IDLE are ignored; no write.
- Simultaneous events:
  - 4th byte_valid in the same cycle load_en falls: the word is still written, then -> IDLE.
  - A frame error does not advance the byte index.
- wr_addr/wr_data hold their last values when wr_en=0.
- word_count and frame_err hold after the session ends, for display.
- Reset mid-frame or mid-word aborts everything; nothing is written.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: checksum = modulo-256 sum of every valid byte accepted in LOAD, cleared at session start. Shown on HEX for host verification.
- Undefined: checksum tied to 8'h00; no adder is inferred.

Decomposition:
- Package loader_pkg:
  - rx state enum {IDLE, START, DATA, STOP}.
  - loader state enum {IDLE, LOAD}.
  - Function computing CLKS_PER_BIT.
  - Constant BYTES_PER_WORD=4.
- Sub-module uart_rx_byte:
  - Contains the synchroniser, baud counter and RX FSM.
  - Outputs byte_data[7:0], byte_valid, stop_err.
  - The top-level block holds the loader FSM and assembler.

Test Plan (CLK_HZ=160, BAUD=10 -> 16 clocks/bit):
1. load_en=1, send 0x24,0x08,0x00,0x05 -> one wr_en pulse, wr_addr=0, wr_data=0x24080005, word_count=1, cpu_hold=1.
2. Send 8 bytes (two words) then load_en=0 -> writes at addr 0 and 4, word_count=2, cpu_hold=0 one cycle after load_en falls; with LOADER_CHECKSUM_EN, checksum = byte sum mod 256.
3. Send 3 bytes, drop load_en, raise it again, send 4 bytes -> exactly one write, at addr 0, containing only the last 4 bytes.
4. Byte with stop bit=0 -> frame_err=1, no index advance; next 4 good bytes form the word; frame_err cleared only at the next session start.
5. rx low pulse of 4 clocks -> no byte_valid, no frame_err; bytes received with load_en=0 -> no wr_en.
6. ADDR_W=3, send 12 bytes -> write addresses 0, 4, 0 (wrap); assert reset mid-byte -> all outputs 0, no write.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the serial program loader
package loader_pkg;

    // UART receiver states
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Loader session states
    typedef enum logic {
        LD_IDLE,
        LD_LOAD
    } ld_state_t;

    localparam int BYTES_PER_WORD = 4;

    // Clock cycles per serial bit; callers must keep the result >= 4
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with input synchroniser
//
// Ports:
//   clock, reset      system clock, async active-high reset
//   rx                serial input, idle high, asynchronous to clock
//   byte_data[7:0]    last received byte (valid with byte_valid)
//   byte_valid        one-cycle pulse: byte received with a good stop bit
//   stop_err          one-cycle pulse: byte received with a low stop bit
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       stop_err
);

    localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);

    rx_state_t        state, state_n;
    logic             rx_s1, rx_s2, rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic             cnt_clr, shift_en, valid_n, err_n;
    logic             tick_half, tick_full;

    assign tick_half = (cnt == CNT_W'(HALF - 1));
    assign tick_full = (cnt == CNT_W'(CPB - 1));

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_clr = 1'b1;
                if (rx_prev && !rx_s2) begin
                    state_n = RX_START;
                end
            end
            RX_START: begin
                // Mid-start-bit re-check rejects short low glitches
                if (tick_half) begin
                    cnt_clr = 1'b1;
                    state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick_full) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_n = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick_full) begin
                    cnt_clr = 1'b1;
                    state_n = RX_IDLE;
                    if (rx_s2) begin
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            bit_idx    <= 3'd0;
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            cnt        <= cnt_clr ? '0 : cnt + 1'b1;
            byte_valid <= valid_n;
            stop_err   <= err_n;
            if (state == RX_IDLE) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            // LSB arrives first, so shift in from the top
            if (shift_en) begin
                byte_data <= {rx_s2, byte_data[7:1]};
            end
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART program loader writing big-endian words to instruction memory
//
// Ports:
//   clock, reset      system clock, async active-high reset
//   rx                UART serial input (8N1)
//   load_en           level-sensitive load session enable
//   wr_en             one-cycle write strobe to instruction memory
//   wr_addr           byte address of the written word (multiple of 4)
//   wr_data           written word
//   cpu_hold          high while a session is active
//   word_count        words written in the current/last session
//   frame_err         sticky low-stop-bit flag, cleared at session start
//   checksum          mod-256 sum of accepted bytes when LOADER_CHECKSUM_EN
//                     is defined, otherwise constant zero
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx,
    input  logic              load_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic [15:0]       word_count,
    output logic              frame_err,
    output logic [7:0]        checksum
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    ld_state_t         state, state_n;
    logic [7:0]        byte_data;
    logic              byte_valid, stop_err;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        idx;
    logic [23:0]       shift;
    logic              start_session;

    uart_rx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .stop_err   (stop_err)
    );

    assign start_session = (state == LD_IDLE) && load_en;
    assign cpu_hold      = (state == LD_LOAD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= LD_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            LD_IDLE: if (load_en)  state_n = LD_LOAD;
            LD_LOAD: if (!load_en) state_n = LD_IDLE;
            default: state_n = LD_IDLE;
        endcase
    end

    // Assembler: bytes shift in MSB-first so the 4th byte completes a big-endian word.
    // A byte completing in the cycle load_en falls is still handled, since state is
    // still LOAD in that cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            idx        <= 2'd0;
            shift      <= 24'h0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 32'h0;
            word_count <= 16'h0;
            frame_err  <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start_session) begin
                addr       <= '0;
                idx        <= 2'd0;
                word_count <= 16'h0;
                frame_err  <= 1'b0;
            end else if (state == LD_LOAD) begin
                if (stop_err) begin
                    frame_err <= 1'b1;
                end
                if (byte_valid) begin
                    shift <= {shift[15:0], byte_data};
                    if (idx == LAST_IDX) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= addr;
                        wr_data    <= {shift, byte_data};
                        addr       <= addr + ADDR_W'(BYTES_PER_WORD);
                        word_count <= word_count + 16'd1;
                        idx        <= 2'd0;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum <= 8'h00;
        end else if (start_session) begin
            sum <= 8'h00;
        end else if ((state == LD_LOAD) && byte_valid) begin
            sum <= sum + byte_data;
        end
    end

    assign checksum = sum;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - directed self-checking bench for uart_prog_loader
module tb_uart_prog_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        load_en = 1'b0;

    logic        wr_en, wr_en3;
    logic [9:0]  wr_addr;
    logic [2:0]  wr_addr3;
    logic [31:0] wr_data, wr_data3;
    logic        cpu_hold, cpu_hold3;
    logic [15:0] word_count, word_count3;
    logic        frame_err, frame_err3;
    logic [7:0]  checksum, checksum3;

    int passed = 0;
    int total  = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] wa3[$];

    uart_prog_loader #(.CLK_HZ(160), .BAUD(10), .ADDR_W(10)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .load_en    (load_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .word_count (word_count),
        .frame_err  (frame_err),
        .checksum   (checksum)
    );

    uart_prog_loader #(.CLK_HZ(160), .BAUD(10), .ADDR_W(3)) u_dut3 (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .load_en    (load_en),
        .wr_en      (wr_en3),
        .wr_addr    (wr_addr3),
        .wr_data    (wr_data3),
        .cpu_hold   (cpu_hold3),
        .word_count (word_count3),
        .frame_err  (frame_err3),
        .checksum   (checksum3)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (wr_en) begin
            wa.push_back(32'(wr_addr));
            wd.push_back(wr_data);
        end
        if (wr_en3) begin
            wa3.push_back(32'(wr_addr3));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wa3.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // 16 clocks per bit; byte_valid and any write land inside the stop bit
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clock);
        rx = 1'b0;
        idle(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(16);
        end
        rx = stop;
        idle(16);
        rx = 1'b1;
        idle(4);
    endtask

    task automatic start_session();
        @(negedge clock);
        load_en = 1'b1;
        idle(3);
    endtask

    task automatic end_session(input string tag);
        @(negedge clock);
        load_en = 1'b0;
        #1;
        check({tag, "_hold_same_cycle"}, 32'(cpu_hold), 32'd1);
        @(posedge clock);
        #1;
        check({tag, "_hold_dropped"}, 32'(cpu_hold), 32'd0);
        idle(3);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_wr_en",      32'(wr_en),      32'd0);
        check("rst_wr_addr",    32'(wr_addr),    32'd0);
        check("rst_wr_data",    wr_data,         32'd0);
        check("rst_cpu_hold",   32'(cpu_hold),   32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_frame_err",  32'(frame_err),  32'd0);
        check("rst_checksum",   32'(checksum),   32'd0);
        idle(2);
        reset = 1'b0;
        idle(4);

        // 1: single word
        clear_log();
        start_session();
        check("t1_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'h24, 1'b1);
        send_byte(8'h08, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h05, 1'b1);
        check("t1_writes", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("t1_addr", wa[0], 32'd0);
            check("t1_data", wd[0], 32'h24080005);
        end
        check("t1_count", 32'(word_count), 32'd1);
        check("t1_hold_after", 32'(cpu_hold), 32'd1);
        end_session("t1");
        check("t1_count_held", 32'(word_count), 32'd1);

        // 2: two words, checksum
        clear_log();
        start_session();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        check("t2_writes", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check("t2_addr0", wa[0], 32'd0);
            check("t2_addr1", wa[1], 32'd4);
            check("t2_data0", wd[0], 32'h11223344);
            check("t2_data1", wd[1], 32'h55667788);
        end
        check("t2_count", 32'(word_count), 32'd2);
`ifdef LOADER_CHECKSUM_EN
        check("t2_checksum", 32'(checksum), 32'h64);
`else
        check("t2_checksum", 32'(checksum), 32'h00);
`endif
        end_session("t2");

        // 3: partial word discarded across a session restart
        clear_log();
        start_session();
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        check("t3_no_partial_write", 32'(wa.size()), 32'd0);
        end_session("t3");
        start_session();
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        check("t3_writes", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("t3_addr", wa[0], 32'd0);
            check("t3_data", wd[0], 32'hDEADBEEF);
        end
        check("t3_count", 32'(word_count), 32'd1);
        end_session("t3b");

        // 4: frame error does not advance the byte index
        clear_log();
        start_session();
        check("t4_ferr_cleared_start", 32'(frame_err), 32'd0);
        send_byte(8'h55, 1'b0);
        check("t4_ferr_set", 32'(frame_err), 32'd1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        check("t4_no_write_yet", 32'(wa.size()), 32'd0);
        send_byte(8'h04, 1'b1);
        check("t4_writes", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("t4_data", wd[0], 32'h01020304);
        end
        end_session("t4");
        check("t4_ferr_held", 32'(frame_err), 32'd1);
        check("t4_count_held", 32'(word_count), 32'd1);

        // 5: glitch rejection and bytes outside a session
        clear_log();
        start_session();
        check("t5_ferr_cleared", 32'(frame_err), 32'd0);
        check("t5_count_cleared", 32'(word_count), 32'd0);
        @(negedge clock);
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        check("t5_glitch_ferr", 32'(frame_err), 32'd0);
        send_byte(8'h0A, 1'b1);
        send_byte(8'h0B, 1'b1);
        send_byte(8'h0C, 1'b1);
        send_byte(8'h0D, 1'b1);
        check("t5_writes", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("t5_data", wd[0], 32'h0A0B0C0D);
        end
        end_session("t5");
        clear_log();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        check("t5_idle_no_write", 32'(wa.size()), 32'd0);

        // 6: address wrap with ADDR_W=3, then reset mid-byte
        clear_log();
        start_session();
        for (int i = 0; i < 12; i++) begin
            send_byte(8'(8'h40 + i), 1'b1);
        end
        check("t6_writes3", 32'(wa3.size()), 32'd3);
        check("t6_writes10", 32'(wa.size()), 32'd3);
        if (wa3.size() == 3) begin
            check("t6_w3_addr0", wa3[0], 32'd0);
            check("t6_w3_addr1", wa3[1], 32'd4);
            check("t6_w3_addr2_wrap", wa3[2], 32'd0);
        end
        if (wa.size() == 3) begin
            check("t6_w10_addr2", wa[2], 32'd8);
            check("t6_w10_data2", wd[2], 32'h48494A4B);
        end
        check("t6_count3", 32'(word_count3), 32'd3);

        clear_log();
        send_byte(8'h99, 1'b1);
        @(negedge clock);
        rx = 1'b0;
        idle(40);
        reset = 1'b1;
        load_en = 1'b0;
        #1;
        check("t6_rst_wr_en",      32'(wr_en),      32'd0);
        check("t6_rst_wr_addr",    32'(wr_addr),    32'd0);
        check("t6_rst_wr_data",    wr_data,         32'd0);
        check("t6_rst_cpu_hold",   32'(cpu_hold),   32'd0);
        check("t6_rst_word_count", 32'(word_count), 32'd0);
        check("t6_rst_frame_err",  32'(frame_err),  32'd0);
        check("t6_rst_checksum",   32'(checksum),   32'd0);
        check("t6_rst_hold3",      32'(cpu_hold3),  32'd0);
        @(negedge clock);
        rx = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(200);
        check("t6_no_write_after_reset", 32'(wa.size()), 32'd0);
        check("t6_no_write3_after_reset", 32'(wa3.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
